// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the 1:4 stream demultiplexer.
package stream_demux_pkg;

    localparam int unsigned N_LANES = 4;

    typedef logic [1:0] lane_sel_t;

    // The caller passes the counter width; values at the width's maximum stay there.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry valid/ready holding register for a single demux output lane.
module demux_slot #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         can_accept
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid      = valid_q;
    assign data       = data_q;
    assign can_accept = ~valid_q | out_ready;

endmodule

// File: rtl/stream_demux_1_4.sv
// 1:4 valid/ready stream demux with one registered slot per lane.
// Optional per-lane saturating transfer counters under `STREAM_DEMUX_COUNT_EN.
module stream_demux_1_4
    import stream_demux_pkg::*;
#(
    parameter int unsigned W     = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    input  logic [1:0]             in_sel,
    output logic [N_LANES-1:0]     out_valid,
    input  logic [N_LANES-1:0]     out_ready,
    output logic [N_LANES*W-1:0]   out_data,
    output logic [N_LANES*CNT_W-1:0] out_count
);

    logic [N_LANES-1:0] load;
    logic [N_LANES-1:0] can_accept;
    logic               in_hs;
    lane_sel_t          sel;

    // Only the selected lane gates the input; load is gated by the handshake so
    // an idle (possibly unknown) in_sel never writes a slot.
    always_comb begin
        sel       = in_sel;
        in_ready  = ~rst & can_accept[sel];
        in_hs     = in_valid & in_ready;
        load      = '0;
        load[sel] = in_hs;
    end

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        demux_slot #(.W(W)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .load       (load[g]),
            .load_data  (in_data),
            .out_ready  (out_ready[g]),
            .valid      (out_valid[g]),
            .data       (out_data[g*W +: W]),
            .can_accept (can_accept[g])
        );
    end

`ifdef STREAM_DEMUX_COUNT_EN
    logic [CNT_W-1:0] cnt_q [N_LANES];
    logic [CNT_W-1:0] cnt_d [N_LANES];

    always_comb begin
        for (int unsigned k = 0; k < N_LANES; k++) begin
            cnt_d[k] = cnt_q[k];
            if (out_valid[k] && out_ready[k]) begin
                cnt_d[k] = CNT_W'(sat_inc(32'(cnt_q[k]), CNT_W));
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < N_LANES; k++) begin
            if (rst) begin
                cnt_q[k] <= '0;
            end else begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    always_comb begin
        out_count = '0;
        for (int unsigned k = 0; k < N_LANES; k++) begin
            out_count[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end
`else
    assign out_count = '0;
`endif

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Directed scoreboard bench for stream_demux_1_4 (per-lane expected-data queues).
module tb_stream_demux_1_4;

    localparam int unsigned W     = 8;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [1:0]       in_sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [4*W-1:0]   out_data;
    logic [4*CNT_W-1:0] out_count;

    stream_demux_1_4 #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [W-1:0] q [4][$];
    logic [3:0]   mv;
    int unsigned  cnt [4];

    task automatic check(input string tag, input int unsigned lane,
                         input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s lane%0d got=%0h exp=%0h", tag, lane, got, exp);
        end
    endtask

    function automatic int unsigned exp_count(input int unsigned k);
`ifdef STREAM_DEMUX_COUNT_EN
        return cnt[k];
`else
        return 0;
`endif
    endfunction

    // Called with inputs already driven (just after a falling edge); samples
    // before the rising edge, updates the model, and returns after the next falling edge.
    task automatic tick();
        logic [3:0] ld;
        logic       exp_rdy;
        #4;
        for (int k = 0; k < 4; k++) begin
            check("valid", k, 32'(out_valid[k]), 32'(mv[k]));
            check("count", k, 32'(out_count[k*CNT_W +: CNT_W]), exp_count(k));
            if (out_valid[k] === 1'b1) begin
                if (q[k].size() == 0) begin
                    check("unexpected_out", k, 32'(out_data[k*W +: W]), 32'hDEAD_BEEF);
                end else begin
                    check("data", k, 32'(out_data[k*W +: W]), 32'(q[k][0]));
                    if (out_ready[k]) begin
                        void'(q[k].pop_front());
                        if (cnt[k] < 255) cnt[k]++;
                    end
                end
            end
        end
        ld = '0;
        if (rst) begin
            check("in_ready_rst", 0, 32'(in_ready), 32'd0);
        end else if (in_valid) begin
            exp_rdy = !mv[in_sel] || out_ready[in_sel];
            check("in_ready", int'(in_sel), 32'(in_ready), 32'(exp_rdy));
            if (exp_rdy) begin
                q[in_sel].push_back(in_data);
                ld[in_sel] = 1'b1;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (ld[k]) mv[k] = 1'b1;
            else if (mv[k] && out_ready[k]) mv[k] = 1'b0;
        end
        if (rst) begin
            mv = '0;
            for (int k = 0; k < 4; k++) begin
                q[k].delete();
                cnt[k] = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] sel, input logic [W-1:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        tick();
    endtask

    task automatic idle(input int unsigned n);
        in_valid = 1'b0;
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    initial begin
        mv = '0;
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        in_data   = 8'hff;
        out_ready = 4'b0000;

        // Reset held for two cycles with in_valid asserted
        tick();
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 4'b1111;
        #1;
        check("rst_valid", 0, 32'(out_valid), 32'd0);
        check("rst_data", 0, out_data, 32'd0);
        check("rst_count", 0, out_count, 32'd0);
        check("rdy_after_rst", 0, 32'(in_ready), 32'd1);
        #0;
        in_valid = 1'b0;
        tick();

        // Routing, back-to-back
        send(2'd0, 8'h0a);
        send(2'd1, 8'h0b);
        send(2'd2, 8'h0c);
        send(2'd3, 8'h0d);
        idle(2);

        // Backpressure on lane 2 must not stall lane 0
        out_ready = 4'b1011;
        send(2'd2, 8'h03);
        send(2'd2, 8'h05);
        send(2'd0, 8'h07);
        out_ready = 4'b1111;
        send(2'd2, 8'h05);
        idle(2);

        // Full-rate streaming on lane 1
        for (int i = 1; i <= 4; i++) send(2'd1, 8'(i));
        idle(2);

        // Idle input with unknown sel/data must not disturb slots
        in_valid = 1'b0;
        in_sel   = 2'bxx;
        in_data  = 'x;
        tick();
        tick();

        // Mid-operation reset with all slots full
        out_ready = 4'b0000;
        send(2'd0, 8'h11);
        send(2'd1, 8'h22);
        send(2'd2, 8'h33);
        send(2'd3, 8'h44);
        idle(1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", 0, 32'(out_valid), 32'd0);
        out_ready = 4'b1111;
        idle(2);

        // Counter saturation on lane 3, small count on lane 0
        for (int i = 0; i < 260; i++) send(2'd3, 8'(i));
        send(2'd0, 8'h55);
        send(2'd0, 8'h66);
        idle(2);
`ifdef STREAM_DEMUX_COUNT_EN
        check("count_sat", 3, 32'(out_count[3*CNT_W +: CNT_W]), 32'd255);
        check("count_small", 0, 32'(out_count[0 +: CNT_W]), 32'd2);
`else
        check("count_off", 3, 32'(out_count[3*CNT_W +: CNT_W]), 32'd0);
        check("count_off", 0, 32'(out_count[0 +: CNT_W]), 32'd0);
`endif
        for (int k = 0; k < 4; k++) check("q_drained", k, q[k].size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
